pipe_stall_ctrl: RTL and testbench

//  Hazard/stall controller for the 5-stage pipeline; drives write-enable and clear of PC,
//  D and E pipeline registers. Stalls D on RAW hazards (Tuse<Tnew vs E/M producers) and on
//  HI/LO access while the multi-cycle mult/div unit (MDU) is busy; bubbles E while stalled.

---
 rtl/pipe_stall_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline.
// Generates PC / D_REG write enables and the E_REG bubble clear from RAW
// hazards against the E and M producers, and from HI/LO access while the
// multi-cycle mult/div unit is busy. Also owns the MDU busy countdown.
// Optional feature: define PIPE_STALL_CNT_EN to get a saturating 32-bit
// stall cycle counter on stall_cnt. Otherwise stall_cnt is tied to zero.
module pipe_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_rs_tuse,
  input  logic [1:0]  d_rt_tuse,
  input  logic        d_is_md,
  input  logic [4:0]  e_a3,
  input  logic [1:0]  e_tnew,
  input  logic [4:0]  m_a3,
  input  logic [1:0]  m_tnew,
  input  logic        e_md_start,
  input  logic        e_md_div,
  output logic        pc_we,
  output logic        d_we,
  output logic        e_clr,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Source operands of the D instruction, indexed 0 = rs, 1 = rt.
  logic [4:0] src_idx  [2];
  logic [1:0] src_tuse [2];
  logic [1:0] stall_src;
  logic       stall_md;
  logic       stall;

  assign src_idx[0]  = d_rs;
  assign src_idx[1]  = d_rt;
  assign src_tuse[0] = d_rs_tuse;
  assign src_tuse[1] = d_rt_tuse;

  // MDU state register; reset throws away any countdown in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // MDU next state: a new start always reloads (latest start wins),
  // otherwise count down and drop back to IDLE after the last busy cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (e_md_start) begin
      state_next = BUSY;
      cnt_next   = e_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (state_reg == BUSY) begin
      if (cnt_reg == CNT_W'(1)) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt_reg - CNT_W'(1);
      end
    end
  end

  // Busy includes the start cycle itself so a following HI/LO access stalls
  // immediately; forced low while reset is held.
  assign md_busy = ~reset & ((state_reg == BUSY) | e_md_start);

  // RAW check per source operand: the producer's result arrives later than
  // the consumer needs it. Register 0 is hardwired and never hazards.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign stall_src[gi] = (src_idx[gi] != 5'd0) &
                             (((src_idx[gi] == e_a3) & (src_tuse[gi] < e_tnew)) |
                              ((src_idx[gi] == m_a3) & (src_tuse[gi] < m_tnew)));
    end
  endgenerate

  assign stall_md = d_is_md & md_busy;
  assign stall    = ~reset & ((|stall_src) | stall_md);

  // Freeze PC and D, and turn the instruction entering E into a bubble.
  assign pc_we = ~stall;
  assign d_we  = ~stall;
  assign e_clr = stall;

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  // Saturating count of stalled cycles since the last reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl. Each cycle the expected
// {pc_we,d_we,e_clr,md_busy} (and optionally stall_cnt) is pushed to a
// scoreboard queue as stimulus is driven, then popped and compared on the
// falling edge. Honours PIPE_STALL_CNT_EN for the stall counter expectation.
module tb_pipe_stall_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic [1:0]  d_rs_tuse;
  logic [1:0]  d_rt_tuse;
  logic        d_is_md;
  logic [4:0]  e_a3;
  logic [1:0]  e_tnew;
  logic [4:0]  m_a3;
  logic [1:0]  m_tnew;
  logic        e_md_start;
  logic        e_md_div;
  logic        pc_we;
  logic        d_we;
  logic        e_clr;
  logic        md_busy;
  logic [31:0] stall_cnt;

`ifdef PIPE_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // {pc_we, d_we, e_clr, md_busy}
  localparam logic [3:0] F_RUN       = 4'b1100;
  localparam logic [3:0] F_STALL     = 4'b0010;
  localparam logic [3:0] F_RUN_BUSY  = 4'b1101;
  localparam logic [3:0] F_STALL_BSY = 4'b0011;

  typedef struct {
    logic [3:0]  flags;
    bit          chk_cnt;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t got;
  int   checks;
  int   errors;

  pipe_stall_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_rs_tuse  (d_rs_tuse),
    .d_rt_tuse  (d_rt_tuse),
    .d_is_md    (d_is_md),
    .e_a3       (e_a3),
    .e_tnew     (e_tnew),
    .m_a3       (m_a3),
    .m_tnew     (m_tnew),
    .e_md_start (e_md_start),
    .e_md_div   (e_md_div),
    .pc_we      (pc_we),
    .d_we       (d_we),
    .e_clr      (e_clr),
    .md_busy    (md_busy),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    reset      = 1'b0;
    d_rs       = 5'd0;
    d_rt       = 5'd0;
    d_rs_tuse  = 2'd3;
    d_rt_tuse  = 2'd3;
    d_is_md    = 1'b0;
    e_a3       = 5'd0;
    e_tnew     = 2'd0;
    m_a3       = 5'd0;
    m_tnew     = 2'd0;
    e_md_start = 1'b0;
    e_md_div   = 1'b0;
  endtask

  task automatic push_exp(input logic [3:0] flags, input bit chk_cnt, input logic [31:0] cnt);
    exp_t e;
    e.flags   = flags;
    e.chk_cnt = chk_cnt;
    e.cnt     = cnt;
    exp_q.push_back(e);
  endtask

  // Reset forces run/no-busy even with hazards and an MDU start present.
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      clear_inputs();
      if (i == 0) begin
        reset = 1'b1; d_rs = 5'd8; d_rs_tuse = 2'd0; e_a3 = 5'd8; e_tnew = 2'd2;
        d_is_md = 1'b1; e_md_start = 1'b1;
        push_exp(F_RUN, 1'b0, 32'd0);
      end else begin
        push_exp(F_RUN, 1'b1, 32'd0);
      end
      @(negedge clk);
      got = exp_q.pop_front();
      checks++;
      if ({pc_we, d_we, e_clr, md_busy} !== got.flags) begin
        errors++;
        $display("FAIL reset[%0d] flags got=%b exp=%b", i, {pc_we, d_we, e_clr, md_busy}, got.flags);
      end
      if (got.chk_cnt) begin
        checks++;
        if (stall_cnt !== got.cnt) begin
          errors++;
          $display("FAIL reset[%0d] stall_cnt got=%0d exp=%0d", i, stall_cnt, got.cnt);
        end
      end
      $display("txn reset[%0d] flags=%b stall_cnt=%0d", i, {pc_we, d_we, e_clr, md_busy}, stall_cnt);
      @(posedge clk); #1;
    end
  endtask

  // RAW hazard table: E and M producers, rs and rt, reg 0, tuse boundaries.
  task automatic test_raw();
    logic [3:0] exp_f;
    for (int i = 0; i < 9; i++) begin
      clear_inputs();
      exp_f = F_RUN;
      case (i)
        0: begin d_rs = 5'd8;  d_rs_tuse = 2'd0; e_a3 = 5'd8;  e_tnew = 2'd2; exp_f = F_STALL; end
        1: begin d_rs = 5'd0;  d_rs_tuse = 2'd0; e_a3 = 5'd0;  e_tnew = 2'd2; end
        2: begin d_rs = 5'd8;  d_rs_tuse = 2'd2; e_a3 = 5'd8;  e_tnew = 2'd2; end
        3: begin d_rt = 5'd9;  d_rt_tuse = 2'd1; m_a3 = 5'd9;  m_tnew = 2'd2; exp_f = F_STALL; end
        4: begin d_rs = 5'd5;  d_rs_tuse = 2'd0; e_a3 = 5'd5;  e_tnew = 2'd1;
                 m_a3 = 5'd5;  m_tnew = 2'd1; exp_f = F_STALL; end
        5: begin d_rt = 5'd0;  d_rt_tuse = 2'd0; m_a3 = 5'd0;  m_tnew = 2'd2; end
        6: begin d_rs = 5'd3;  d_rs_tuse = 2'd3; e_a3 = 5'd3;  e_tnew = 2'd2; end
        7: begin d_rt = 5'd12; d_rt_tuse = 2'd0; e_a3 = 5'd13; e_tnew = 2'd2; end
        default: begin d_rt = 5'd20; d_rt_tuse = 2'd1; e_a3 = 5'd20; e_tnew = 2'd2; exp_f = F_STALL; end
      endcase
      push_exp(exp_f, 1'b0, 32'd0);
      @(negedge clk);
      got = exp_q.pop_front();
      checks++;
      if ({pc_we, d_we, e_clr, md_busy} !== got.flags) begin
        errors++;
        $display("FAIL raw[%0d] flags got=%b exp=%b", i, {pc_we, d_we, e_clr, md_busy}, got.flags);
      end
      $display("txn raw[%0d] flags=%b", i, {pc_we, d_we, e_clr, md_busy});
      @(posedge clk); #1;
    end
  endtask

  // One mult start with an MD instruction held in D: 6 busy/stall cycles.
  task automatic test_mdu_mult();
    for (int i = 0; i < 8; i++) begin
      clear_inputs();
      d_is_md = 1'b1;
      if (i == 0) e_md_start = 1'b1;
      push_exp((i <= 5) ? F_STALL_BSY : F_RUN, 1'b0, 32'd0);
      @(negedge clk);
      got = exp_q.pop_front();
      checks++;
      if ({pc_we, d_we, e_clr, md_busy} !== got.flags) begin
        errors++;
        $display("FAIL mult[%0d] flags got=%b exp=%b", i, {pc_we, d_we, e_clr, md_busy}, got.flags);
      end
      $display("txn mult[%0d] flags=%b", i, {pc_we, d_we, e_clr, md_busy});
      @(posedge clk); #1;
    end
  endtask

  // Div at t0, mult restart at t3: busy through t3+5 only, not the div length.
  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      clear_inputs();
      if (i == 0) begin e_md_start = 1'b1; e_md_div = 1'b1; end
      if (i == 3) begin e_md_start = 1'b1; e_md_div = 1'b0; end
      push_exp((i <= 8) ? F_RUN_BUSY : F_RUN, 1'b0, 32'd0);
      @(negedge clk);
      got = exp_q.pop_front();
      checks++;
      if ({pc_we, d_we, e_clr, md_busy} !== got.flags) begin
        errors++;
        $display("FAIL b2b[%0d] flags got=%b exp=%b", i, {pc_we, d_we, e_clr, md_busy}, got.flags);
      end
      $display("txn b2b[%0d] flags=%b", i, {pc_we, d_we, e_clr, md_busy});
      @(posedge clk); #1;
    end
  endtask

  // Reset three cycles into a div discards the countdown.
  task automatic test_reset_mid_busy();
    logic [3:0] exp_f;
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      exp_f = F_RUN;
      case (i)
        0: begin e_md_start = 1'b1; e_md_div = 1'b1; exp_f = F_RUN_BUSY; end
        1, 2: exp_f = F_RUN_BUSY;
        3: reset = 1'b1;
        default: d_is_md = 1'b1;
      endcase
      push_exp(exp_f, 1'b0, 32'd0);
      @(negedge clk);
      got = exp_q.pop_front();
      checks++;
      if ({pc_we, d_we, e_clr, md_busy} !== got.flags) begin
        errors++;
        $display("FAIL rst_busy[%0d] flags got=%b exp=%b", i, {pc_we, d_we, e_clr, md_busy}, got.flags);
      end
      $display("txn rst_busy[%0d] flags=%b", i, {pc_we, d_we, e_clr, md_busy});
      @(posedge clk); #1;
    end
  endtask

  // After reset, 4 RAW stall cycles then idle: counter reaches 4 and holds.
  task automatic test_stall_cnt();
    for (int i = 0; i < 7; i++) begin
      clear_inputs();
      if (i == 0) begin
        reset = 1'b1;
        push_exp(F_RUN, 1'b0, 32'd0);
      end else if (i <= 4) begin
        d_rs = 5'd8; d_rs_tuse = 2'd0; e_a3 = 5'd8; e_tnew = 2'd2;
        push_exp(F_STALL, 1'b1, CNT_EN ? 32'(i - 1) : 32'd0);
      end else begin
        push_exp(F_RUN, 1'b1, CNT_EN ? 32'd4 : 32'd0);
      end
      @(negedge clk);
      got = exp_q.pop_front();
      checks++;
      if ({pc_we, d_we, e_clr, md_busy} !== got.flags) begin
        errors++;
        $display("FAIL cnt[%0d] flags got=%b exp=%b", i, {pc_we, d_we, e_clr, md_busy}, got.flags);
      end
      if (got.chk_cnt) begin
        checks++;
        if (stall_cnt !== got.cnt) begin
          errors++;
          $display("FAIL cnt[%0d] stall_cnt got=%0d exp=%0d", i, stall_cnt, got.cnt);
        end
      end
      $display("txn cnt[%0d] flags=%b stall_cnt=%0d", i, {pc_we, d_we, e_clr, md_busy}, stall_cnt);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_raw();
    test_mdu_mult();
    test_back_to_back();
    test_reset_mid_busy();
    test_stall_cnt();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
